// File: rtl/qupls4_xform_seq.sv
// qupls4_xform_seq: initiator-side sequencer for the Qupls4 graphics transform unit.
// Latency: point accepted at cycle T -> xf_ld high at T+1; done first sampled at W -> res_valid at W+5.
// Backpressure: result held stable in OUT until res_ready; pt_ready only in IDLE and never while m_wr_req.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   m_wr_req/m_idx/m_data/m_ack matrix coefficient write request and its issue pulse
//   pt_valid/pt_ready/pt_x/y/z  input point handshake
//   res_valid/res_ready/res_*   result beat (x', y', z', err)
//   err_mismatch                sticky coefficient readback mismatch (0 unless readback is built in)
//   busy                        sequencer not idle
//   xf_op/ld/wr/a/b, xf_o/done  transform unit port (all outputs registered)
//
// Build option: define QUPLS4_XFORM_READBACK_EN to read back and compare every coefficient write.

module qupls4_xform_seq #(
   parameter int TIMEOUT = 255,
   parameter int DW      = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m_wr_req,
   input  logic [3:0]    m_idx,
   input  logic [DW-1:0] m_data,
   output logic          m_ack,
   input  logic          pt_valid,
   output logic          pt_ready,
   input  logic [DW-1:0] pt_x,
   input  logic [DW-1:0] pt_y,
   input  logic [DW-1:0] pt_z,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_x,
   output logic [DW-1:0] res_y,
   output logic [DW-1:0] res_z,
   output logic          res_err,
   output logic          err_mismatch,
   output logic          busy,
   output logic [1:0]    xf_op,
   output logic          xf_ld,
   output logic          xf_wr,
   output logic [63:0]   xf_a,
   output logic [63:0]   xf_b,
   input  logic [63:0]   xf_o,
   input  logic          xf_done
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_MWR,
      S_MRB1,
      S_MRB2,
      S_LD,
      S_GUARD,
      S_WAIT,
      S_RDX,
      S_RDY,
      S_RDZ,
      S_RDW,
      S_OUT
   } state_t;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t        state;
   logic [CW-1:0] wait_cnt;

   // Only the low DW bits of the unit result carry a coordinate.
   logic unused_o;
   assign unused_o = ^xf_o[63:DW];

   assign pt_ready = (state == S_IDLE) && !m_wr_req;
   assign busy     = (state != S_IDLE);

`ifndef QUPLS4_XFORM_READBACK_EN
   assign err_mismatch = 1'b0;
`endif

   // Outputs are registered on the transition into the state that "drives" them,
   // so each value is visible on the unit port for exactly the cycle the FSM sits there.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         xf_op     <= 2'd0;
         xf_ld     <= 1'b0;
         xf_wr     <= 1'b0;
         xf_a      <= 64'd0;
         xf_b      <= 64'd0;
         m_ack     <= 1'b0;
         res_valid <= 1'b0;
         res_err   <= 1'b0;
         res_x     <= '0;
         res_y     <= '0;
         res_z     <= '0;
`ifdef QUPLS4_XFORM_READBACK_EN
         err_mismatch <= 1'b0;
`endif
      end else begin
         // single-cycle strobes
         m_ack <= 1'b0;
         xf_ld <= 1'b0;
         xf_wr <= 1'b0;

         case (state)
            S_IDLE: begin
               if (m_wr_req) begin
                  state <= S_MWR;
                  xf_op <= 2'd3;
                  xf_wr <= 1'b1;
                  xf_a  <= {60'd0, m_idx};
                  xf_b  <= 64'(m_data);
`ifndef QUPLS4_XFORM_READBACK_EN
                  m_ack <= 1'b1;
`endif
               end else if (pt_valid) begin
                  state <= S_LD;
                  xf_ld <= 1'b1;
                  xf_a  <= 64'({pt_y, pt_x});
                  xf_b  <= 64'(pt_z);
               end
            end

`ifdef QUPLS4_XFORM_READBACK_EN
            // xf_op stays 3 with wr low: the unit reads back the same index.
            S_MWR: state <= S_MRB1;

            S_MRB1: begin
               state <= S_MRB2;
               xf_op <= 2'd0;
               m_ack <= 1'b1;
            end

            // xf_o now holds the readback; xf_b still holds the written value.
            S_MRB2: begin
               state <= S_IDLE;
               if (xf_a[3:2] != 2'b11 && xf_o[DW-1:0] != xf_b[DW-1:0])
                  err_mismatch <= 1'b1;
            end
`else
            S_MWR: begin
               state <= S_IDLE;
               xf_op <= 2'd0;
            end
`endif

            S_LD: state <= S_GUARD;

            // The unit's done flag is stale for one cycle after ld.
            S_GUARD: begin
               wait_cnt <= '0;
               state    <= S_WAIT;
            end

            S_WAIT: begin
               if (xf_done) begin
                  state <= S_RDX;
               end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                  res_err   <= 1'b1;
                  res_x     <= '0;
                  res_y     <= '0;
                  res_z     <= '0;
                  res_valid <= 1'b1;
                  state     <= S_OUT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            // xf_o lags xf_op by one cycle, so each capture takes the previous op's result.
            S_RDX: begin
               xf_op <= 2'd1;
               state <= S_RDY;
            end

            S_RDY: begin
               res_x <= xf_o[DW-1:0];
               xf_op <= 2'd2;
               state <= S_RDZ;
            end

            S_RDZ: begin
               res_y <= xf_o[DW-1:0];
               xf_op <= 2'd0;
               state <= S_RDW;
            end

            S_RDW: begin
               res_z     <= xf_o[DW-1:0];
               res_err   <= 1'b0;
               res_valid <= 1'b1;
               state     <= S_OUT;
            end

            S_OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qupls4_xform_seq.sv
// tb_qupls4_xform_seq: directed bench for qupls4_xform_seq with a small transform-unit model.
// Main instance uses default TIMEOUT; a second instance with TIMEOUT=16 covers the timeout path.
// Inputs driven 1 time unit after the rising edge, outputs sampled 1-2 units after it.

module tb_qupls4_xform_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic        rst;
   logic        m_wr_req;
   logic [3:0]  m_idx;
   logic [31:0] m_data;
   logic        m_ack;
   logic        pt_valid, pt_ready;
   logic [31:0] pt_x, pt_y, pt_z;
   logic        res_valid, res_ready;
   logic [31:0] res_x, res_y, res_z;
   logic        res_err, err_mismatch, busy;
   logic [1:0]  xf_op;
   logic        xf_ld, xf_wr;
   logic [63:0] xf_a, xf_b, xf_o;
   logic        xf_done;

   // timeout instance signals
   logic        t_m_wr_req, t_m_ack;
   logic        t_pt_valid, t_pt_ready;
   logic        t_res_valid, t_res_ready;
   logic [31:0] t_res_x, t_res_y, t_res_z;
   logic        t_res_err, t_err_mismatch, t_busy;
   logic [1:0]  t_xf_op;
   logic        t_xf_ld, t_xf_wr;
   logic [63:0] t_xf_a, t_xf_b, t_xf_o;
   logic        t_xf_done;

   qupls4_xform_seq u_dut (
      .clk(clk), .rst(rst),
      .m_wr_req(m_wr_req), .m_idx(m_idx), .m_data(m_data), .m_ack(m_ack),
      .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_x(res_x), .res_y(res_y), .res_z(res_z), .res_err(res_err),
      .err_mismatch(err_mismatch), .busy(busy),
      .xf_op(xf_op), .xf_ld(xf_ld), .xf_wr(xf_wr), .xf_a(xf_a), .xf_b(xf_b),
      .xf_o(xf_o), .xf_done(xf_done)
   );

   qupls4_xform_seq #(.TIMEOUT(16), .DW(32)) u_to (
      .clk(clk), .rst(rst),
      .m_wr_req(t_m_wr_req), .m_idx(m_idx), .m_data(m_data), .m_ack(t_m_ack),
      .pt_valid(t_pt_valid), .pt_ready(t_pt_ready), .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z),
      .res_valid(t_res_valid), .res_ready(t_res_ready),
      .res_x(t_res_x), .res_y(t_res_y), .res_z(t_res_z), .res_err(t_res_err),
      .err_mismatch(t_err_mismatch), .busy(t_busy),
      .xf_op(t_xf_op), .xf_ld(t_xf_ld), .xf_wr(t_xf_wr), .xf_a(t_xf_a), .xf_b(t_xf_b),
      .xf_o(t_xf_o), .xf_done(t_xf_done)
   );

   // Transform unit model: registered result reflecting the previous cycle's op.
   logic [31:0] coef [0:15];
   logic [31:0] mdl_x, mdl_y, mdl_z;
   logic        corrupt;

   always @(posedge clk) begin
      if (xf_op == 2'd3 && xf_wr) coef[xf_a[3:0]] <= xf_b[31:0];
      case (xf_op)
         2'd0:    xf_o <= {32'd0, mdl_x};
         2'd1:    xf_o <= {32'd0, mdl_y};
         2'd2:    xf_o <= {32'd0, mdl_z};
         default: xf_o <= {32'd0, coef[xf_a[3:0]] ^ ((corrupt && xf_a[3:0] == 4'd5) ? 32'h1 : 32'h0)};
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if ({xf_op, xf_ld, xf_wr, m_ack, res_valid, res_err, busy, err_mismatch} !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got op=%0d ld=%b wr=%b ack=%b rv=%b err=%b busy=%b mm=%b, want all 0",
                  xf_op, xf_ld, xf_wr, m_ack, res_valid, res_err, busy, err_mismatch);
      end
      n_checks++;
      if ({xf_a, xf_b, res_x, res_y, res_z} !== 224'd0) begin
         n_fail++;
         $display("FAIL reset_data: got a=%h b=%h x=%h y=%h z=%h, want 0", xf_a, xf_b, res_x, res_y, res_z);
      end
      n_checks++;
      if ({pt_ready, t_res_valid, t_busy, t_xf_op} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_misc: got pt_ready=%b t_rv=%b t_busy=%b t_op=%0d, want 1 0 0 0",
                  pt_ready, t_res_valid, t_busy, t_xf_op);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_matrix_load();
      logic [3:0]  k;
      logic [31:0] d;
      for (int i = 0; i < 13; i++) begin
         k = (i < 12) ? 4'(i) : 4'd13;
         d = 32'h3F80_0000 + 32'(k);
         m_wr_req = 1'b1; m_idx = k; m_data = d; pt_valid = 1'b1;
         #1;
         n_checks++;
         if ({pt_ready, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL mwr_idle idx=%0d: got pt_ready=%b busy=%b, want 0 0", k, pt_ready, busy);
         end
         tick();  // MWR
         n_checks++;
         if ({xf_op, xf_wr, xf_ld, pt_ready} !== 5'b11100 || xf_a !== {60'd0, k} || xf_b !== {32'd0, d}) begin
            n_fail++;
            $display("FAIL mwr_issue idx=%0d: got op=%0d wr=%b ld=%b rdy=%b a=%h b=%h, want op=3 wr=1 a=%h b=%h",
                     k, xf_op, xf_wr, xf_ld, pt_ready, xf_a, xf_b, {60'd0, k}, {32'd0, d});
         end
`ifdef QUPLS4_XFORM_READBACK_EN
         n_checks++;
         if (m_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL mwr_ack_early idx=%0d: got %b want 0", k, m_ack);
         end
         tick();  // MRB1
         n_checks++;
         if ({xf_op, xf_wr, m_ack} !== 4'b1100 || xf_a[3:0] !== k) begin
            n_fail++;
            $display("FAIL mrb1 idx=%0d: got op=%0d wr=%b ack=%b a=%h, want op=3 wr=0 ack=0", k, xf_op, xf_wr, m_ack, xf_a);
         end
         tick();  // MRB2
         n_checks++;
         if ({m_ack, xf_op} !== 3'b100) begin
            n_fail++;
            $display("FAIL mrb2 idx=%0d: got ack=%b op=%0d, want ack=1 op=0", k, m_ack, xf_op);
         end
`else
         n_checks++;
         if (m_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL mwr_ack idx=%0d: got %b want 1", k, m_ack);
         end
`endif
         if (i == 12) begin
            m_wr_req = 1'b0;
            pt_valid = 1'b0;
         end
         tick();  // back in IDLE
         n_checks++;
         if ({m_ack, xf_op, xf_wr, busy} !== 5'd0) begin
            n_fail++;
            $display("FAIL mwr_done idx=%0d: got ack=%b op=%0d wr=%b busy=%b, want 0", k, m_ack, xf_op, xf_wr, busy);
         end
      end
      n_checks++;
      if (err_mismatch !== 1'b0) begin
         n_fail++;
         $display("FAIL load_mismatch: got %b want 0", err_mismatch);
      end
   endtask

   task automatic test_point_lat100();
      mdl_x = 32'h11; mdl_y = 32'h22; mdl_z = 32'h33;
      pt_x = 32'h4000_0000; pt_y = 32'h4040_0000; pt_z = 32'h4080_0000; pt_valid = 1'b1;
      #1;
      n_checks++;
      if (pt_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL p100_accept: got pt_ready=%b want 1", pt_ready);
      end
      tick();  // T+1
      pt_valid = 1'b0;
      n_checks++;
      if (xf_ld !== 1'b1 || xf_a !== 64'h4040_0000_4000_0000 || xf_b !== 64'h4080_0000) begin
         n_fail++;
         $display("FAIL p100_ld: got ld=%b a=%h b=%h, want 1 4040000040000000 0000000040800000", xf_ld, xf_a, xf_b);
      end
      tick();  // T+2
      n_checks++;
      if ({xf_ld, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL p100_guard: got ld=%b busy=%b, want 0 1", xf_ld, busy);
      end
      repeat (98) tick();  // T+100 = W
      n_checks++;
      if ({res_valid, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL p100_waiting: got rv=%b busy=%b, want 0 1", res_valid, busy);
      end
      xf_done = 1'b1;
      tick();
      xf_done = 1'b0;
      repeat (3) tick();  // W+4
      n_checks++;
      if (res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL p100_early: got rv=%b at W+4 want 0", res_valid);
      end
      tick();  // W+5
      n_checks++;
      if ({res_valid, res_err} !== 2'b10 || res_x !== 32'h11 || res_y !== 32'h22 || res_z !== 32'h33) begin
         n_fail++;
         $display("FAIL p100_result: got rv=%b err=%b x=%h y=%h z=%h, want 1 0 11 22 33",
                  res_valid, res_err, res_x, res_y, res_z);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      n_checks++;
      if ({res_valid, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL p100_release: got rv=%b busy=%b, want 0 0", res_valid, busy);
      end
   endtask

   task automatic test_fixed_pulse();
      mdl_x = 32'h0001_0000; mdl_y = 32'h0002_0000; mdl_z = 32'h0003_0000;
      pt_x = 32'h1; pt_y = 32'h2; pt_z = 32'h3; pt_valid = 1'b1;
      tick();  // T+1 LD
      pt_valid = 1'b0;
      n_checks++;
      if (xf_a !== 64'h0000_0002_0000_0001 || xf_b !== 64'h3) begin
         n_fail++;
         $display("FAIL pulse_ld: got a=%h b=%h, want 0000000200000001 3", xf_a, xf_b);
      end
      tick();  // T+2 GUARD, stale done
      xf_done = 1'b1;
      tick();  // T+3
      xf_done = 1'b0;
      tick();  // T+4, real one-cycle pulse
      xf_done = 1'b1;
      tick();  // T+5 RDX
      xf_done = 1'b0;
      tick();  // T+6 RDY
      n_checks++;
      if (xf_op !== 2'd1) begin
         n_fail++;
         $display("FAIL pulse_rdy_op: got %0d want 1", xf_op);
      end
      tick();  // T+7 RDZ
      n_checks++;
      if ({xf_op, res_valid} !== 3'b100) begin
         n_fail++;
         $display("FAIL pulse_rdz: got op=%0d rv=%b, want 2 0", xf_op, res_valid);
      end
      tick();  // T+8 RDW
      n_checks++;
      if ({xf_op, res_valid} !== 3'b000) begin
         n_fail++;
         $display("FAIL pulse_rdw: got op=%0d rv=%b, want 0 0", xf_op, res_valid);
      end
      tick();  // T+9 OUT
      n_checks++;
      if ({res_valid, res_err} !== 2'b10 || res_x !== 32'h0001_0000 || res_y !== 32'h0002_0000 || res_z !== 32'h0003_0000) begin
         n_fail++;
         $display("FAIL pulse_result: got rv=%b err=%b x=%h y=%h z=%h, want 1 0 00010000 00020000 00030000",
                  res_valid, res_err, res_x, res_y, res_z);
      end
   endtask

   task automatic test_backpressure();
      mdl_x = 32'h44; mdl_y = 32'h55; mdl_z = 32'h66;
      pt_x = 32'h5; pt_y = 32'h6; pt_z = 32'h7; pt_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         n_checks++;
         if ({res_valid, res_err, pt_ready, busy} !== 4'b1001 ||
             res_x !== 32'h0001_0000 || res_y !== 32'h0002_0000 || res_z !== 32'h0003_0000) begin
            n_fail++;
            $display("FAIL bp_hold c=%0d: got rv=%b err=%b rdy=%b busy=%b x=%h y=%h z=%h",
                     c, res_valid, res_err, pt_ready, busy, res_x, res_y, res_z);
         end
         tick();
      end
      res_ready = 1'b1;
      #1;
      n_checks++;
      if (pt_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_same_cycle: got pt_ready=%b want 0", pt_ready);
      end
      tick();  // IDLE
      res_ready = 1'b0;
      n_checks++;
      if ({res_valid, busy, pt_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL bp_idle: got rv=%b busy=%b rdy=%b, want 0 0 1", res_valid, busy, pt_ready);
      end
      tick();  // T+1 LD of next point
      pt_valid = 1'b0;
      n_checks++;
      if (xf_ld !== 1'b1 || xf_a !== 64'h0000_0006_0000_0005 || xf_b !== 64'h7) begin
         n_fail++;
         $display("FAIL bp_next_ld: got ld=%b a=%h b=%h, want 1 0000000600000005 7", xf_ld, xf_a, xf_b);
      end
      tick();  // T+2 GUARD, done already high
      xf_done = 1'b1;
      tick();  // T+3 first WAIT, done still high
      tick();  // T+4 RDX
      xf_done = 1'b0;
      repeat (3) tick();  // T+7
      n_checks++;
      if (res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_guard_early: got rv=%b at T+7 want 0", res_valid);
      end
      tick();  // T+8
      n_checks++;
      if (res_valid !== 1'b1 || res_x !== 32'h44 || res_y !== 32'h55 || res_z !== 32'h66) begin
         n_fail++;
         $display("FAIL bp_guard_result: got rv=%b x=%h y=%h z=%h, want 1 44 55 66", res_valid, res_x, res_y, res_z);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_timeout();
      t_pt_valid = 1'b1;
      tick();  // LD
      t_pt_valid = 1'b0;
      tick();  // GUARD
      tick();  // WAIT
      t_xf_done = 1'b1;
      tick();
      t_xf_done = 1'b0;
      repeat (4) tick();
      n_checks++;
      if ({t_res_valid, t_res_err} !== 2'b10 || t_res_x !== 32'hDEAD_BEEF || t_res_z !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL to_normal: got rv=%b err=%b x=%h z=%h, want 1 0 deadbeef deadbeef",
                  t_res_valid, t_res_err, t_res_x, t_res_z);
      end
      t_res_ready = 1'b1;
      tick();
      t_res_ready = 1'b0;
      t_pt_valid = 1'b1;
      tick();  // T+1
      t_pt_valid = 1'b0;
      tick();  // T+2
      tick();  // T+3 enter WAIT
      repeat (15) tick();  // T+18
      n_checks++;
      if ({t_res_valid, t_busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL to_early: got rv=%b busy=%b at WAIT+15, want 0 1", t_res_valid, t_busy);
      end
      tick();  // T+19
      n_checks++;
      if ({t_res_valid, t_res_err} !== 2'b11 || {t_res_x, t_res_y, t_res_z} !== 96'd0 || t_xf_op !== 2'd0) begin
         n_fail++;
         $display("FAIL to_result: got rv=%b err=%b x=%h y=%h z=%h op=%0d, want 1 1 0 0 0 0",
                  t_res_valid, t_res_err, t_res_x, t_res_y, t_res_z, t_xf_op);
      end
      t_res_ready = 1'b1;
      tick();
      t_res_ready = 1'b0;
      n_checks++;
      if ({t_res_valid, t_busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL to_release: got rv=%b busy=%b, want 0 0", t_res_valid, t_busy);
      end
   endtask

`ifdef QUPLS4_XFORM_READBACK_EN
   task automatic test_readback();
      logic [3:0] idx_tab [0:2];
      logic       exp_tab [0:2];
      idx_tab[0] = 4'd6; idx_tab[1] = 4'd5; idx_tab[2] = 4'd6;
      exp_tab[0] = 1'b0; exp_tab[1] = 1'b1; exp_tab[2] = 1'b1;
      corrupt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         m_wr_req = 1'b1; m_idx = idx_tab[i]; m_data = 32'h4100_0000 + 32'(i);
         tick();  // MWR
         tick();  // MRB1
         tick();  // MRB2
         m_wr_req = 1'b0;
         tick();  // IDLE, compare result registered
         n_checks++;
         if (err_mismatch !== exp_tab[i]) begin
            n_fail++;
            $display("FAIL rb_mismatch step=%0d idx=%0d: got %b want %b", i, idx_tab[i], err_mismatch, exp_tab[i]);
         end
      end
      corrupt = 1'b0;
   endtask
`endif

   task automatic test_reset_in_rdy();
      mdl_x = 32'h77; mdl_y = 32'h88; mdl_z = 32'h99;
      pt_valid = 1'b1;
      tick();  // LD
      pt_valid = 1'b0;
      tick();  // GUARD
      tick();  // WAIT
      xf_done = 1'b1;
      tick();  // RDX
      xf_done = 1'b0;
      tick();  // RDY
      n_checks++;
      if ({xf_op, busy} !== 3'b011) begin
         n_fail++;
         $display("FAIL rst_pre_rdy: got op=%0d busy=%b, want 1 1", xf_op, busy);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({xf_op, xf_ld, xf_wr, m_ack, res_valid, res_err, busy, err_mismatch} !== 9'd0 ||
          {xf_a, xf_b, res_x, res_y, res_z} !== 224'd0) begin
         n_fail++;
         $display("FAIL rst_async: got op=%0d rv=%b busy=%b mm=%b a=%h x=%h y=%h z=%h, want all 0",
                  xf_op, res_valid, busy, err_mismatch, xf_a, res_x, res_y, res_z);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         n_checks++;
         if ({res_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_no_result c=%0d: got rv=%b busy=%b, want 0 0", c, res_valid, busy);
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      m_wr_req = 1'b0; m_idx = 4'd0; m_data = 32'd0;
      pt_valid = 1'b0; pt_x = 32'd0; pt_y = 32'd0; pt_z = 32'd0;
      res_ready = 1'b0; xf_done = 1'b0;
      t_m_wr_req = 1'b0; t_pt_valid = 1'b0; t_res_ready = 1'b0; t_xf_done = 1'b0;
      t_xf_o = 64'h0000_0000_DEAD_BEEF;
      mdl_x = 32'd0; mdl_y = 32'd0; mdl_z = 32'd0; corrupt = 1'b0;

      test_reset();
      test_matrix_load();
      test_point_lat100();
      test_fixed_pulse();
      test_backpressure();
      test_timeout();
`ifdef QUPLS4_XFORM_READBACK_EN
      test_readback();
`endif
      test_reset_in_rdy();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/qupls4_xform_seq.md
Name: qupls4_xform_seq

Overview:
- Initiator-side sequencer for the Qupls4 graphics transform unit.
- Accepts matrix-coefficient writes and a stream of 3-D points from the CPU/graphics front end, and drives the unit's op/ld/wr/a/b port.
- Waits for the unit's done flag, then reads back x', y' and z' via op 0..2 and presents them as one result beat on a valid/ready output.

Parameters:
- TIMEOUT, 255: maximum cycles spent in WAIT before the point is abandoned with an error.
- DW, 32: coordinate/coefficient width (float32 or fixed-point bit pattern, passed through untouched).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m_wr_req  in  1  matrix coefficient write request
- m_idx  in  4  coefficient index (0 aa .. 11 tz)
- m_data  in  DW  coefficient value
- m_ack  out  1  one-cycle pulse when the write has been issued
- pt_valid  in  1  point available
- pt_ready  out  1  point accepted when pt_valid and pt_ready are both high
- pt_x, pt_y, pt_z  in  DW each  input point
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_x, res_y, res_z  out  DW each  transformed point
- res_err  out  1  result is invalid (timeout)
- busy  out  1  state != IDLE
- xf_op  out  2  unit op
- xf_ld  out  1  unit ld
- xf_wr  out  1  unit wr
- xf_a  out  64  unit a
- xf_b  out  64  unit b
- xf_o  in  64  unit o (registered; reflects the previous cycle's op)
- xf_done  in  1  unit done

Behaviour:
- Reset (async):
  - State goes to IDLE.
  - All outputs go to 0: xf_op=0, xf_ld=0, xf_wr=0, xf_a=0, xf_b=0, m_ack=0, res_valid=0, res_err=0, res_x/y/z=0.
  - Reset mid-operation abandons the point with no result. The unit itself is not reset by this block.
- All xf_* outputs are registered. xf_op idles at 2'd0 and never carries 3 except during a matrix write (or readback, when the optional feature is compiled in).
- Combinational ready:
  - pt_ready = (state==IDLE) && !m_wr_req. Matrix writes take priority over points.
- IDLE:
  - If m_wr_req: go to MWR.
  - Else if pt_valid: latch the point and go to LD.
- MWR (1 cycle):
  - Drive xf_op=3, xf_wr=1, xf_a={60'b0,m_idx}, xf_b={32'b0,m_data}, m_ack=1.
  - Go to IDLE.
  - Indices 12..15 are still issued (the unit ignores them) and still acked.
- LD (1 cycle):
  - Drive xf_ld=1, xf_a={pt_y,pt_x}, xf_b={32'b0,pt_z}.
  - Go to GUARD.
- GUARD (1 cycle):
  - xf_done is ignored, because the unit's done is stale for one cycle after ld.
  - Load the wait counter with 0 and go to WAIT.
- WAIT:
  - If xf_done=1: go to RDX.
  - Else if the counter reaches TIMEOUT-1: set res_err=1, res_x/y/z=0, go to OUT.
  - Else increment the counter.
  - xf_done is treated as a sampled level, so a single-cycle pulse (fixed-point build) is sufficient.
- RDX: xf_op=0.
- RDY: xf_op=1, res_x <= xf_o[DW-1:0].
- RDZ: xf_op=2, res_y <= xf_o[DW-1:0].
- RDW: res_z <= xf_o[DW-1:0], res_err=0, xf_op returns to 0.
- OUT:
  - res_valid=1. Outputs are held stable while res_ready=0.
  - On res_ready: res_valid=0, go to IDLE.
  - No new point is accepted in the same cycle.
- Latency:
  - Accept at cycle T; xf_ld is high at T+1.
  - If xf_done is first sampled high at cycle W (W >= T+3), res_valid rises at W+5.
- xf_done already high in GUARD: ignored; it is sampled again in WAIT (first WAIT cycle is T+3).

Optional Feature:
- Macro QUPLS4_XFORM_READBACK_EN.
- When defined:
  - MWR is followed by MRB1 (xf_op=3, xf_wr=0, same index) and then MRB2, which compares xf_o[DW-1:0] against m_data.
  - m_ack pulses in MRB2, not in MWR.
  - A mismatch sets sticky output err_mismatch (cleared only by rst).
  - Indices 12..15 skip the comparison.
- When undefined:
  - A write is the single MWR cycle described above.
  - err_mismatch exists and is tied to 0.

Test Plan:
- Matrix load: 12 writes, idx 0..11, data 0x3F800000+idx -> each cycle shows xf_op=3, xf_wr=1, xf_a[3:0]=idx, m_ack pulse; no pt_ready while m_wr_req is held.
- Point with model done latency 100:
  - Stimulus: accept at T, pt_x=0x40000000, pt_y=0x40400000, pt_z=0x40800000.
  - Response: xf_ld at T+1 with xf_a=0x4040000040000000, xf_b=0x40800000.
  - Model returns 0x11/0x22/0x33 for op 0/1/2 -> res_valid at W+5 with those values, res_err=0.
- Fixed-point pulse: done is a 1-cycle pulse 3 cycles after ld -> captured; result correct; a stale done=1 during GUARD is ignored.
- Backpressure: res_ready low for 10 cycles -> res_* stable, pt_ready=0 throughout; res_ready high -> IDLE the next cycle and the next point accepted.
- Timeout: TIMEOUT=16, done never rises -> res_valid with res_err=1 and zeros 16 cycles after entering WAIT.
- Async reset asserted in RDY -> all outputs 0 immediately, state IDLE, no result emitted; with QUPLS4_XFORM_READBACK_EN, a model corrupting index 5 -> err_mismatch=1 sticky.
